// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (data bits, parity, stop bits) fed by a small write FIFO.
// Latency: a write accepted at edge N into an idle, empty block drives the start bit on tx from edge N+2.
// Backpressure: full=1 while FIFO_DEPTH entries are queued; a write while full is dropped without side effects.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input and the BREAK/guard sequence.
module uart_tx_param #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 500000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
`ifdef UART_TX_BREAK_EN
    input  logic                          send_break,
`endif
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx,
    output logic                          busy
);

    // ------------------------------------------------------------------
    // Derived timing and sizing
    // ------------------------------------------------------------------
    // Rounded integer bit period; every bit lasts exactly this many clocks.
    localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int PAR_EN     = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_EN + STOP_BITS;
`ifdef UART_TX_BREAK_EN
    // A break holds the line low one bit longer than a whole frame.
    localparam int BRK_CYCLES = (FRAME_BITS + 1) * BIT_CYCLES;
    localparam int CNT_MAX    = BRK_CYCLES;
`else
    localparam int CNT_MAX    = STOP_BITS * BIT_CYCLES;
`endif
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int LW         = AW + 1;
    localparam int IDX_W      = $clog2(DATA_BITS);

    // Counter reload values; the counter runs from LOAD down to zero, so a
    // state lasts LOAD+1 cycles.
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS * BIT_CYCLES - 1);
`ifdef UART_TX_BREAK_EN
    localparam logic [CNT_W-1:0] BRK_LOAD  = CNT_W'(BRK_CYCLES - 1);
`endif
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic [LW-1:0]    FULL_LVL  = LW'(FIFO_DEPTH);

    // FSM encoding
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
    localparam logic [2:0] S_GUARD  = 3'd6;
`endif

    // ------------------------------------------------------------------
    // Parameter legality, rejected at elaboration
    // ------------------------------------------------------------------
    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx_param: BIT_CYCLES = (CLK_FREQ + BAUD/2)/BAUD must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two and >= 2");
    end

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LW-1:0]        r_level;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = wr_en & ~w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Transmit FSM state
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 w_bit_done;
    logic                 w_par_bit;
    logic                 w_tx_nxt;
`ifdef UART_TX_BREAK_EN
    logic                 w_brk_go;
`endif

    assign w_bit_done = (r_cnt == '0);
    // The accumulator holds the XOR of the data bits; odd parity inverts it.
    assign w_par_bit  = (PARITY == 1) ? ~r_par : r_par;
`ifdef UART_TX_BREAK_EN
    // A break is only honoured from an idle line with nothing queued.
    assign w_brk_go   = send_break & (r_state == S_IDLE) & w_empty;
`endif

    // Pop the head entry when idle, or at the very end of a stop period so
    // the next frame starts with no idle gap.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == S_IDLE) begin
                w_pop = 1'b1;
            end else if (r_state == S_STOP && w_bit_done) begin
                w_pop = 1'b1;
            end
        end
    end

    // Payload storage; stale contents are harmless because the pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Frame sequencer: bit timing, data shifting and parity accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= 1'b0;
                        r_cnt   <= BIT_LOAD;
                        r_state <= S_START;
                    end
`ifdef UART_TX_BREAK_EN
                    else if (w_brk_go) begin
                        r_cnt   <= BRK_LOAD;
                        r_state <= S_BREAK;
                    end
`endif
                end

                S_START: begin
                    if (w_bit_done) begin
                        r_idx   <= '0;
                        r_cnt   <= BIT_LOAD;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        // Fold the bit just sent into the parity, then expose the next one.
                        r_par   <= r_par ^ r_shift[0];
                        r_shift <= r_shift >> 1;
                        if (r_idx == LAST_IDX) begin
                            if (PAR_EN != 0) begin
                                r_cnt   <= BIT_LOAD;
                                r_state <= S_PARITY;
                            end else begin
                                r_cnt   <= STOP_LOAD;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_cnt <= BIT_LOAD;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt   <= STOP_LOAD;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_done) begin
                        if (w_pop) begin
                            // Back-to-back: next start bit follows the stop bit directly.
                            r_shift <= w_head;
                            r_par   <= 1'b0;
                            r_cnt   <= BIT_LOAD;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (w_bit_done) begin
                        r_cnt   <= BIT_LOAD;
                        r_state <= S_GUARD;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                S_GUARD: begin
                    if (w_bit_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Line level implied by the current state; registered below.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
            S_PARITY: w_tx_nxt = w_par_bit;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  w_tx_nxt = 1'b0;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // Output flop keeps tx glitch-free; it trails the state by one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_nxt;
        end
    end

    assign tx    = r_tx;
    assign full  = w_full;
    assign level = r_level;
    assign busy  = (r_state != S_IDLE) | ~w_empty;

endmodule
